// File: rtl/dbg_uart_cmd_engine.sv
// Byte-stream debug command engine: decodes host frames from the UART RX FIFO into
// dbg_module commands with burst auto-increment, NAK replies and an inter-byte timeout.
module dbg_uart_cmd_engine #(
    parameter int unsigned ADDR_BYTES     = 4,
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h01,
    parameter logic [7:0]  END_BYTE       = 8'h02,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_valid_i,
    output logic                    rx_ready_o,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic [7:0]              dbg_cmd_o,
    output logic [8*ADDR_BYTES-1:0] dbg_addr_o,
    output logic [8*DATA_BYTES-1:0] dbg_data_o,
    input  logic [8*DATA_BYTES-1:0] dbg_data_i,
    input  logic                    dbg_ready_i,
    output logic                    busy_o,
    output logic                    timeout_o
);
    localparam int unsigned AW   = 8*ADDR_BYTES;
    localparam int unsigned DW   = 8*DATA_BYTES;
    localparam int unsigned MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int unsigned BCW  = (MAXB > 2) ? 2 : 1;
    localparam int unsigned TCW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD_RSP, S_ADDR, S_WDATA, S_EXEC, S_RDATA, S_END, S_ABORT
    } state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_cmd;
    logic            r_nak;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rbuf;
    logic [BCW-1:0]  r_byte_cnt;
    logic [6:0]      r_beat;
    logic [TCW-1:0]  r_to_cnt;
    logic            r_armed;
    logic [7:0]      r_dbg_cmd;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;

    logic            w_rx_ready, w_busy, w_timeout, w_sending;
    logic            w_accept, w_tx_fire, w_exec_done, w_rx_nak;
    logic            w_last_addr, w_last_data, w_last_beat;
    logic [BCW-1:0]  w_tx_idx;
    logic [7:0]      w_tx_byte;

    assign w_accept    = rx_valid_i && w_rx_ready;
    assign w_tx_fire   = r_tx_valid && tx_ready_i;
    assign w_exec_done = r_armed && dbg_ready_i;
    assign w_last_addr = (r_byte_cnt == BCW'(ADDR_BYTES - 1));
    assign w_last_data = (r_byte_cnt == BCW'(DATA_BYTES - 1));
    assign w_last_beat = (r_beat == {1'b0, r_cmd[5:0]});
    assign w_rx_nak    = rx_data_i[7] && (({1'b0, rx_data_i[5:0]} + 7'd1) > 7'(MAX_BURST));
    assign w_tx_idx    = w_tx_fire ? r_byte_cnt + 1'b1 : r_byte_cnt;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_CMD_RSP;
            S_CMD_RSP: if (w_tx_fire) w_next = r_nak ? S_IDLE : (r_cmd[7] ? S_ADDR : S_EXEC);
            S_ADDR: begin
                if (w_timeout)                     w_next = S_ABORT;
                else if (w_accept && w_last_addr)  w_next = r_cmd[6] ? S_WDATA : S_EXEC;
            end
            S_WDATA: begin
                if (w_timeout)                     w_next = S_ABORT;
                else if (w_accept && w_last_data)  w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_exec_done) begin
                    if (!r_cmd[7])      w_next = S_END;
                    else if (r_cmd[6])  w_next = w_last_beat ? S_END : S_WDATA;
                    else                w_next = S_RDATA;
                end
            end
            S_RDATA:   if (w_tx_fire && w_last_data) w_next = w_last_beat ? S_END : S_EXEC;
            S_END:     if (w_tx_fire) w_next = S_IDLE;
            S_ABORT:   if (w_tx_fire) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rx_ready = 1'b0;
        w_sending  = 1'b0;
        w_timeout  = 1'b0;
        w_busy     = (r_state != S_IDLE);
        w_tx_byte  = 8'h00;
        case (r_state)
            S_IDLE: w_rx_ready = 1'b1;
            S_ADDR, S_WDATA: begin
                w_rx_ready = 1'b1;
                w_timeout  = !rx_valid_i && (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));
            end
            S_CMD_RSP: begin
                w_sending = 1'b1;
                w_tx_byte = r_nak ? NAK_BYTE : ACK_BYTE;
            end
            S_RDATA: begin
                w_sending = 1'b1;
                w_tx_byte = r_rbuf[8*w_tx_idx +: 8];
            end
            S_END: begin
                w_sending = 1'b1;
                w_tx_byte = END_BYTE;
            end
            S_ABORT: begin
                w_sending = 1'b1;
                w_tx_byte = NAK_BYTE;
            end
            default: ;
        endcase
    end

    // The beat counter spans the whole burst, so it only clears while waiting for a new frame.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cmd      <= '0;
            r_nak      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rbuf     <= '0;
            r_byte_cnt <= '0;
            r_beat     <= '0;
            r_to_cnt   <= '0;
            r_armed    <= 1'b0;
            r_dbg_cmd  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_beat <= '0;
                if (w_accept) begin
                    r_cmd <= rx_data_i;
                    r_nak <= w_rx_nak;
                end
            end else if ((w_exec_done && r_cmd[7] && r_cmd[6]) ||
                         (r_state == S_RDATA && w_tx_fire && w_last_data)) begin
                r_beat <= r_beat + 1'b1;
            end

            if (r_state != w_next)
                r_byte_cnt <= '0;
            else if (w_accept || (r_state == S_RDATA && w_tx_fire))
                r_byte_cnt <= r_byte_cnt + 1'b1;

            if (r_state == S_ADDR && w_accept)
                r_addr[8*r_byte_cnt +: 8] <= rx_data_i;
            else if (w_exec_done && r_cmd[7])
                r_addr <= r_addr + AW'(DATA_BYTES);

            if (r_state == S_WDATA && w_accept)
                r_wdata[8*r_byte_cnt +: 8] <= rx_data_i;

            if ((r_state == S_ADDR || r_state == S_WDATA) && !w_accept)
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;

            // Arming one cycle after EXEC entry is what makes a ready on the entry cycle ignored.
            if (r_state == S_EXEC && !r_armed) begin
                r_armed   <= 1'b1;
                r_dbg_cmd <= r_cmd[7] ? {r_cmd[7:6], 6'b0} : r_cmd;
            end else if (w_exec_done) begin
                r_armed   <= 1'b0;
                r_dbg_cmd <= '0;
                r_rbuf    <= dbg_data_i;
            end

            if (r_state != w_next) begin
                r_tx_valid <= 1'b0;
            end else if (w_sending && (!r_tx_valid || w_tx_fire)) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_tx_byte;
            end
        end
    end

    assign rx_ready_o = w_rx_ready;
    assign busy_o     = w_busy;
    assign timeout_o  = w_timeout;
    assign tx_valid_o = r_tx_valid;
    assign tx_data_o  = r_tx_data;
    assign dbg_cmd_o  = r_dbg_cmd;
    assign dbg_addr_o = r_addr;
    assign dbg_data_o = r_wdata;

endmodule

// File: tb/tb_dbg_uart_cmd_engine.sv
// Scoreboard bench for dbg_uart_cmd_engine: a frame-level model queues expected TX bytes
// and dbg transactions; independent monitors pop and compare them as the DUT presents them.
module tb_dbg_uart_cmd_engine;
    localparam int AB   = 4;
    localparam int DB   = 4;
    localparam int MAXB = 16;
    localparam int TMO  = 100;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;
    logic        busy_o;
    logic        timeout_o;

    dbg_uart_cmd_engine #(
        .ADDR_BYTES(AB), .DATA_BYTES(DB), .MAX_BURST(MAXB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstn_i(rstn_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
        .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chkAddr;
        bit          chkData;
        logic [31:0] rdata;
        int          dly;
    } dbgTxn_t;

    logic [7:0]  expTx[$];
    dbgTxn_t     expDbg[$];
    int          errors = 0;
    int          checks = 0;
    bit          holdTx = 1'b0;
    bit          respHold = 1'b0;
    logic [31:0] wbuf[64];
    logic [31:0] rbuf[64];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name, input int val);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0d, expected nothing", name, val);
    endtask

    // TX sink with random readiness unless a test freezes it.
    initial begin
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready_i = holdTx ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // TX monitor: every transferred byte must be the next one the model predicted.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn_i && tx_valid_o && tx_ready_i) begin
                if (expTx.size() == 0) reportFail("unexpectedTx", int'(tx_data_o));
                else                   checkOutput("txByte", tx_data_o, expTx.pop_front());
            end
        end
    end

    // dbg_module responder and monitor: compares each command, holds it for the chosen
    // delay, then answers with the read data the model attached to that transaction.
    initial begin
        dbgTxn_t     t;
        logic [7:0]  c;
        logic [31:0] a, d;
        bit          ok;
        dbg_ready_i = 1'b0;
        dbg_data_i  = '0;
        forever begin
            @(negedge clk);
            if (rstn_i && dbg_cmd_o != 8'h00 && !respHold) begin
                c = dbg_cmd_o; a = dbg_addr_o; d = dbg_data_o;
                if (expDbg.size() == 0) begin
                    reportFail("unexpectedDbg", int'(c));
                    t = '{cmd: c, addr: 0, data: 0, chkAddr: 0, chkData: 0, rdata: 0, dly: 0};
                end else begin
                    t = expDbg.pop_front();
                    checkOutput("dbgCmd", c, t.cmd);
                    if (t.chkAddr) checkOutput("dbgAddr", a, t.addr);
                    if (t.chkData) checkOutput("dbgData", d, t.data);
                end
                ok = 1'b1;
                for (int i = 0; i < t.dly; i++) begin
                    @(negedge clk);
                    if (dbg_cmd_o !== c || dbg_addr_o !== a || dbg_data_o !== d) ok = 1'b0;
                end
                dbg_ready_i = 1'b1;
                dbg_data_i  = t.rdata;
                @(negedge clk);
                dbg_ready_i = 1'b0;
                dbg_data_i  = $urandom;
                if (dbg_cmd_o !== 8'h00) ok = 1'b0;
                checkOutput("dbgPulse", ok, 1'b1);
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int guard = 0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk);
        while (!rx_ready_o && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) reportFail("rxStall", int'(b));
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((expTx.size() != 0 || expDbg.size() != 0 || busy_o) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            reportFail("frameTimeout", expTx.size() + expDbg.size());
            expTx.delete();
            expDbg.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Frame model: derives replies and beats from the command byte, then drives the host side.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr, input int dly);
        int          beats;
        logic [31:0] a;
        dbgTxn_t     t;
        beats = int'(cmd[5:0]) + 1;
        a     = addr;
        if (cmd[7] && beats > MAXB) begin
            expTx.push_back(8'h15);
            sendByte(cmd);
            waitIdle();
            return;
        end
        expTx.push_back(8'h01);
        if (!cmd[7]) begin
            t = '{cmd: cmd, addr: 0, data: 0, chkAddr: 0, chkData: 0, rdata: $urandom,
                  dly: (dly < 0) ? $urandom_range(0, 4) : dly};
            expDbg.push_back(t);
        end else begin
            for (int b = 0; b < beats; b++) begin
                t.cmd     = cmd[6] ? 8'hC0 : 8'h80;
                t.addr    = a;
                t.chkAddr = 1'b1;
                t.dly     = (dly < 0) ? $urandom_range(0, 4) : dly;
                if (cmd[6]) begin
                    t.data = wbuf[b]; t.chkData = 1'b1; t.rdata = $urandom;
                end else begin
                    t.data = '0; t.chkData = 1'b0; t.rdata = rbuf[b];
                    for (int k = 0; k < DB; k++) expTx.push_back(rbuf[b][8*k +: 8]);
                end
                expDbg.push_back(t);
                a = a + 32'(DB);
            end
        end
        expTx.push_back(8'h02);
        sendByte(cmd);
        if (cmd[7]) begin
            for (int k = 0; k < AB; k++) sendByte(addr[8*k +: 8]);
            if (cmd[6])
                for (int b = 0; b < beats; b++)
                    for (int k = 0; k < DB; k++) sendByte(wbuf[b][8*k +: 8]);
        end
        waitIdle();
    endtask

    initial begin
        int          n;
        bit          stable, rxBlocked;
        logic [7:0]  first, cmd;
        logic [31:0] addr;

        rstn_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstCtl", {tx_valid_o, busy_o, timeout_o}, 3'b000);
        checkOutput("rstTxData", tx_data_o, 8'h00);
        checkOutput("rstDbgCmd", dbg_cmd_o, 8'h00);
        checkOutput("rstDbgAddr", dbg_addr_o, 32'h0);
        checkOutput("rstDbgData", dbg_data_o, 32'h0);
        rstn_i = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] non-memory command");
        applyStimulus(8'h03, 32'h0, 2);

        $display("[TB] burst write");
        wbuf[0] = 32'h44332211; wbuf[1] = 32'h88776655;
        applyStimulus(8'hC1, 32'h00000010, -1);

        $display("[TB] read with address wrap");
        rbuf[0] = 32'hDEADBEEF;
        applyStimulus(8'h80, 32'hFFFFFFFC, 1);
        rbuf[1] = $urandom;
        applyStimulus(8'h81, 32'hFFFFFFFC, -1);

        $display("[TB] burst length limits");
        for (int b = 0; b < 64; b++) begin wbuf[b] = $urandom; rbuf[b] = $urandom; end
        applyStimulus(8'hCF, $urandom, 0);
        applyStimulus(8'h90, $urandom, -1);
        expTx.push_back(8'h15);
        sendByte(8'hBF);
        n = 0;
        while (!(tx_valid_o && tx_ready_i) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) reportFail("nakWait", n);
        repeat (2) @(negedge clk);
        checkOutput("nakBusy", busy_o, 1'b0);
        waitIdle();

        $display("[TB] inter-byte timeout");
        expTx.push_back(8'h01);
        expTx.push_back(8'h15);
        sendByte(8'h80);
        sendByte(8'h34);
        sendByte(8'h12);
        n = 0;
        do begin @(negedge clk); n++; end while (!timeout_o && n < 300);
        checkOutput("timeoutCycle", n, 100);
        @(negedge clk);
        checkOutput("timeoutPulse", timeout_o, 1'b0);
        waitIdle();

        $display("[TB] TX backpressure");
        addr = $urandom;
        rbuf[0] = $urandom;
        expTx.push_back(8'h01);
        for (int k = 0; k < DB; k++) expTx.push_back(rbuf[0][8*k +: 8]);
        expTx.push_back(8'h02);
        expDbg.push_back('{cmd: 8'h80, addr: addr, data: 0, chkAddr: 1, chkData: 0,
                           rdata: rbuf[0], dly: 1});
        sendByte(8'h80);
        sendByte(addr[7:0]);
        holdTx = 1'b1;
        for (int k = 1; k < AB; k++) sendByte(addr[8*k +: 8]);
        n = 0;
        while (!tx_valid_o && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) reportFail("bpWait", n);
        first = tx_data_o;
        stable = 1'b1; rxBlocked = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_data_o !== first || !tx_valid_o) stable = 1'b0;
            if (rx_ready_o) rxBlocked = 1'b0;
        end
        checkOutput("bpStable", stable, 1'b1);
        checkOutput("bpRxReady", rxBlocked, 1'b1);
        holdTx = 1'b0;
        waitIdle();

        $display("[TB] reset during EXEC");
        respHold = 1'b1;
        expTx.push_back(8'h01);
        sendByte(8'h05);
        n = 0;
        while (dbg_cmd_o == 8'h00 && n < 200) begin @(negedge clk); n++; end
        checkOutput("execCmd", dbg_cmd_o, 8'h05);
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("rstMidCmd", dbg_cmd_o, 8'h00);
        checkOutput("rstMidCtl", {tx_valid_o, busy_o, timeout_o}, 3'b000);
        checkOutput("rstMidData", {dbg_addr_o, dbg_data_o, tx_data_o}, 72'h0);
        @(negedge clk);
        rstn_i = 1'b1;
        respHold = 1'b0;
        expTx.delete();
        @(posedge clk);
        #1;

        $display("[TB] random frames");
        for (int f = 0; f < 30; f++) begin
            for (int b = 0; b < 64; b++) begin wbuf[b] = $urandom; rbuf[b] = $urandom; end
            if ($urandom_range(0, 3) == 0) cmd = 8'($urandom_range(1, 127));
            else cmd = {1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 19))};
            applyStimulus(cmd, $urandom, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
